fetch_pc_unit: RTL

Fetch-side neighbour of the decode-stage branch comparator. Holds the architectural PC register and the IF/ID pipeline register. Consumes the comparator's branch decision plus decoded jump information from D, and produces the next fetch address. Implements the MIPS single delay slot, stall hold, and an optional branch-likely delay-slot annul.

---
 rtl/fetch_pc_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: architectural PC and IF/ID register with the MIPS single delay slot.
// Define BRANCH_LIKELY_EN to annul the delay slot of a not-taken branch-likely.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [31:0]      im_instr,
    input  logic             d_branch,
    input  logic             d_likely,
    input  logic             d_to_branch,
    input  logic [1:0]       d_jump,
    input  logic [31:0]      d_jr_target,
    output logic [31:0]      f_pc,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_instr,
    output logic [31:0]      d_pc8,
    output logic             d_valid,
    output logic             redirect,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [31:0]      r_f_pc;
    logic [31:0]      r_d_pc;
    logic [31:0]      r_d_instr;
    logic             r_d_valid;
    logic [CNT_W-1:0] r_taken_count;

    logic [31:0] w_d_pc4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_is_jump;
    logic        w_redirect;
    logic        w_annul;

    assign w_d_pc4     = r_d_pc + 32'd4;
    assign w_br_offset = {{14{r_d_instr[15]}}, r_d_instr[15:0], 2'b00};
    assign w_br_target = w_d_pc4 + w_br_offset;
    assign w_j_target  = {w_d_pc4[31:28], r_d_instr[25:0], 2'b00};
    assign w_is_jump   = (d_jump == 2'b01) || (d_jump == 2'b10);
    assign w_redirect  = r_d_valid & ((d_branch & d_to_branch) | w_is_jump);

    // A jump outranks a simultaneously flagged branch; encoding 11 falls back to the branch path.
    always_comb begin
        w_target = w_br_target;
        case (d_jump)
            2'b01:   w_target = w_j_target;
            2'b10:   w_target = d_jr_target;
            default: w_target = w_br_target;
        endcase
    end

    assign w_next_pc = w_redirect ? w_target : (r_f_pc + 32'd4);

`ifdef BRANCH_LIKELY_EN
    assign w_annul = r_d_valid & d_branch & d_likely & ~d_to_branch;
`else
    logic w_unused_likely;
    assign w_unused_likely = d_likely;
    assign w_annul         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f_pc        <= RESET_PC;
            r_d_pc        <= RESET_PC;
            r_d_instr     <= '0;
            r_d_valid     <= 1'b0;
            r_taken_count <= '0;
        end else if (!stall) begin
            r_f_pc    <= w_next_pc;
            r_d_pc    <= r_f_pc;
            r_d_instr <= w_annul ? 32'd0 : im_instr;
            r_d_valid <= ~w_annul;
            if (w_redirect && (r_taken_count != '1)) begin
                r_taken_count <= r_taken_count + CNT_ONE;
            end
        end
    end

    assign f_pc        = r_f_pc;
    assign d_pc        = r_d_pc;
    assign d_instr     = r_d_instr;
    assign d_pc8       = r_d_pc + 32'd8;
    assign d_valid     = r_d_valid;
    assign redirect    = w_redirect;
    assign taken_count = r_taken_count;

endmodule
